// File: rtl/conv_sched_pkg.sv
// Shared types and limits for the data_ram read scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Largest kernel and stride the config ports can express
  localparam int unsigned K_MAX = 15;
  localparam int unsigned S_MAX = 3;

  localparam int unsigned KW          = $clog2(K_MAX + 1);
  localparam int unsigned SW          = $clog2(S_MAX + 1);
  localparam int unsigned DIM_W       = 6;
  localparam int unsigned RAM_ADDR_DW = 5;
  localparam int unsigned IMG_IDX_W   = 9;
  // Loop-end compares and the zero-extended kx output use this width
  localparam int unsigned CMP_W       = 8;

endpackage

// File: rtl/wrap_cnt.sv
// Up-counter that steps by 'step' when enabled and wraps to zero on 'last'.
module wrap_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         last,
  input  logic [W-1:0] step,
  output logic [W-1:0] cnt,
  output logic         carry_c
);

  // Carry into the next loop level when this level wraps
  assign carry_c = en & last;

  // Count register: clear on load, otherwise step or wrap on enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : W'(cnt + step);
    end
  end

endmodule

// File: rtl/data_ram_rd_sched.sv
// Convolution-window read scheduler driving data_ram one kernel tap per cycle.
module data_ram_rd_sched
  import conv_sched_pkg::*;
#(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned RAM_NUM = 32,
  parameter int unsigned ADDR_DW = RAM_ADDR_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KW-1:0]        kernel_dim,
  input  logic [SW-1:0]        stride,
  input  logic [DIM_W-1:0]     in_dim,
  input  logic [IMG_IDX_W-1:0] image_base,
  input  logic                 ready,
  output logic [CMP_W-1:0]     addr_r_x,
  output logic [KW-1:0]        addr_r_y,
  output logic [ADDR_DW-1:0]   ram_select_r_x,
  output logic [ADDR_DW-1:0]   ram_select_r_y,
  output logic [IMG_IDX_W-1:0] image_index,
  output logic [KW-1:0]        kernel_dim_o,
  output logic [SW-1:0]        stride_o,
  output logic                 data_out_valid,
  output logic                 data_ready,
  output logic                 tap_first,
  output logic                 tap_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e state_q, state_d;

  logic [DIM_W-1:0]   in_dim_q;
  logic [KW-1:0]      kx, ky;
  logic [ADDR_DW-1:0] sel_x, sel_y;
  logic [ADDR_DW-1:0] step_x_c, step_y_c;
  logic               cfg_err_c, issue_c, cnt_clr_c;
  logic               kx_last_c, ky_last_c, row_last_c, grp_last_c;
  logic               kx_carry_c, ky_carry_c, row_carry_c, grp_carry_c;

  // Config legality, evaluated on the live inputs when start is accepted
  assign cfg_err_c = (kernel_dim == '0) | (stride == '0) | (in_dim == '0) |
                     (CMP_W'(in_dim) > CMP_W'(RAM_NUM)) |
                     (CMP_W'(kernel_dim) > CMP_W'(in_dim));

  assign issue_c        = (state_q == ST_RUN) & ready;
  assign data_out_valid = issue_c;

  assign step_x_c = ADDR_DW'(ROWS * stride_o);
  assign step_y_c = ADDR_DW'(stride_o);

  // Loop-end detection by look-ahead compare instead of dividing in_dim
  assign kx_last_c  = (kx == KW'(kernel_dim_o - KW'(1)));
  assign ky_last_c  = (ky == KW'(kernel_dim_o - KW'(1)));
  assign row_last_c = (CMP_W'(sel_y) + CMP_W'(stride_o) + CMP_W'(kernel_dim_o)) >
                      CMP_W'(in_dim_q);
  assign grp_last_c = (CMP_W'(sel_x) + CMP_W'(step_x_c) + CMP_W'(kernel_dim_o)) >
                      CMP_W'(in_dim_q);

  wrap_cnt #(.W(KW)) u_kx (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr_c), .en(issue_c), .last(kx_last_c),
    .step(KW'(1)), .cnt(kx), .carry_c(kx_carry_c)
  );

  wrap_cnt #(.W(KW)) u_ky (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr_c), .en(kx_carry_c), .last(ky_last_c),
    .step(KW'(1)), .cnt(ky), .carry_c(ky_carry_c)
  );

  wrap_cnt #(.W(ADDR_DW)) u_row (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr_c), .en(ky_carry_c), .last(row_last_c),
    .step(step_y_c), .cnt(sel_y), .carry_c(row_carry_c)
  );

  wrap_cnt #(.W(ADDR_DW)) u_grp (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr_c), .en(row_carry_c), .last(grp_last_c),
    .step(step_x_c), .cnt(sel_x), .carry_c(grp_carry_c)
  );

  assign addr_r_x       = CMP_W'(kx);
  assign addr_r_y       = ky;
  assign ram_select_r_x = sel_x;
  assign ram_select_r_y = sel_y;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; LOAD clears the loop counters
  always_comb begin
    state_d   = state_q;
    cnt_clr_c = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        cnt_clr_c = 1'b1;
        state_d   = err ? ST_IDLE : ST_RUN;
      end
      ST_RUN:   if (grp_carry_c) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered status, read-return flags and latched config
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      data_ready   <= 1'b0;
      tap_first    <= 1'b0;
      tap_last     <= 1'b0;
      image_index  <= '0;
      kernel_dim_o <= '0;
      stride_o     <= '0;
      in_dim_q     <= '0;
    end else begin
      err        <= (state_q == ST_IDLE) & start & cfg_err_c;
      busy       <= (state_d != ST_IDLE);
      done       <= (state_d == ST_DONE);
      data_ready <= issue_c;
      tap_first  <= issue_c & (kx == '0) & (ky == '0);
      tap_last   <= issue_c & kx_last_c & ky_last_c;
      if ((state_q == ST_IDLE) && start) begin
        image_index  <= image_base;
        kernel_dim_o <= kernel_dim;
        stride_o     <= stride;
        in_dim_q     <= in_dim;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_rd_sched.sv
// Randomised-ready bench for data_ram_rd_sched against a loop-count reference model.
module tb_data_ram_rd_sched;

  localparam int ROWS = 8;

  logic       clk = 1'b0;
  logic       rst_n, start, ready;
  logic [3:0] kernel_dim;
  logic [1:0] stride;
  logic [5:0] in_dim;
  logic [8:0] image_base;
  logic [7:0] addr_r_x;
  logic [3:0] addr_r_y;
  logic [4:0] ram_select_r_x, ram_select_r_y;
  logic [8:0] image_index;
  logic [3:0] kernel_dim_o;
  logic [1:0] stride_o;
  logic       data_out_valid, data_ready, tap_first, tap_last, busy, done, err;

  int n_checks;
  int n_errors;

  // Expected issue sequence for the current pass
  int exp_sx[$], exp_sy[$], exp_ky[$], exp_kx[$];
  int exp_vectors;

  data_ram_rd_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_dim(kernel_dim), .stride(stride),
    .in_dim(in_dim), .image_base(image_base), .ready(ready),
    .addr_r_x(addr_r_x), .addr_r_y(addr_r_y),
    .ram_select_r_x(ram_select_r_x), .ram_select_r_y(ram_select_r_y),
    .image_index(image_index), .kernel_dim_o(kernel_dim_o), .stride_o(stride_o),
    .data_out_valid(data_out_valid), .data_ready(data_ready),
    .tap_first(tap_first), .tap_last(tap_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_x"}, 32'(addr_r_x), 0);
    check({tag, "_addr_y"}, 32'(addr_r_y), 0);
    check({tag, "_sel_x"}, 32'(ram_select_r_x), 0);
    check({tag, "_sel_y"}, 32'(ram_select_r_y), 0);
    check({tag, "_img"}, 32'(image_index), 0);
    check({tag, "_k_o"}, 32'(kernel_dim_o), 0);
    check({tag, "_s_o"}, 32'(stride_o), 0);
    check({tag, "_dov"}, 32'(data_out_valid), 0);
    check({tag, "_dr"}, 32'(data_ready), 0);
    check({tag, "_tf"}, 32'(tap_first), 0);
    check({tag, "_tl"}, 32'(tap_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  // Output count per axis is floor((D-K)/S)+1; groups cover ROWS outputs each
  task automatic build_exp(input int k, input int s, input int d);
    int nout, ngrp;
    exp_sx.delete(); exp_sy.delete(); exp_ky.delete(); exp_kx.delete();
    nout = (d - k) / s + 1;
    ngrp = (nout + ROWS - 1) / ROWS;
    exp_vectors = ngrp * nout;
    for (int g = 0; g < ngrp; g++)
      for (int r = 0; r < nout; r++)
        for (int y = 0; y < k; y++)
          for (int x = 0; x < k; x++) begin
            exp_sx.push_back(g * ROWS * s);
            exp_sy.push_back(r * s);
            exp_ky.push_back(y);
            exp_kx.push_back(x);
          end
  endtask

  task automatic run_pass(input int k, input int s, input int d, input int stall_pct,
                          input int abort_at, input int base);
    int   idx, n, budget, done_cyc, last_iss, dov_obs, tl_obs;
    logic prev_iss, prev_first, prev_last, iss;
    build_exp(k, s, d);
    n = exp_sx.size();
    budget = 4 * n + 50;
    @(posedge clk); #1;
    start = 1'b1; kernel_dim = 4'(k); stride = 2'(s); in_dim = 6'(d);
    image_base = 9'(base); ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    kernel_dim = 4'($urandom); stride = 2'($urandom); in_dim = 6'($urandom);
    image_base = 9'($urandom);
    idx = 0; done_cyc = -1; last_iss = 0; dov_obs = 0; tl_obs = 0;
    prev_iss = 1'b0; prev_first = 1'b0; prev_last = 1'b0;
    for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
      ready = ($urandom_range(99) >= 32'(stall_pct));
      start = (cyc == 40) && (idx + 5 < n);
      @(negedge clk);
      if (cyc == 1) check("err_legal", 32'(err), 0);
      check("busy", 32'(busy), 1);
      check("data_ready", 32'(data_ready), 32'(prev_iss));
      check("tap_first", 32'(tap_first), 32'(prev_first));
      check("tap_last", 32'(tap_last), 32'(prev_last));
      iss = 1'b0;
      if (cyc >= 2 && idx < n) begin
        check("dov", 32'(data_out_valid), 32'(ready));
        check("sel_x", 32'(ram_select_r_x), exp_sx[idx]);
        check("sel_y", 32'(ram_select_r_y), exp_sy[idx]);
        check("ky", 32'(addr_r_y), exp_ky[idx]);
        check("kx", 32'(addr_r_x), exp_kx[idx]);
        iss = ready;
      end else begin
        check("dov_idle", 32'(data_out_valid), 0);
      end
      dov_obs += int'(data_out_valid);
      tl_obs  += int'(tap_last);
      prev_iss = iss;
      prev_first = iss && exp_ky[idx] == 0 && exp_kx[idx] == 0;
      prev_last  = iss && exp_ky[idx] == k - 1 && exp_kx[idx] == k - 1;
      if (iss) begin
        idx++;
        last_iss = cyc;
      end
      check("done", 32'(done), 32'(idx == n && cyc == last_iss + 2));
      if (done === 1'b1) begin
        done_cyc = cyc;
        check("image_index", 32'(image_index), 32'(base));
        check("kernel_dim_o", 32'(kernel_dim_o), 32'(k));
        check("stride_o", 32'(stride_o), 32'(s));
      end
      if (abort_at > 0 && idx == abort_at) begin
        #1 rst_n = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    check("completed", 32'(done_cyc >= 0), 1);
    check("issue_count", 32'(dov_obs), 32'(n));
    check("tap_last_count", 32'(tl_obs), 32'(exp_vectors));
    if (stall_pct == 0) check("done_latency", 32'(done_cyc), 32'(n + 3));
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
  endtask

  // Illegal config: err in cycle 1, a repeated start in LOAD is ignored, nothing issues
  task automatic run_err(input int k, input int s, input int d);
    @(posedge clk); #1;
    start = 1'b1; kernel_dim = 4'(k); stride = 2'(s); in_dim = 6'(d); ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("err_c1", 32'(err), 1);
    check("err_busy_c1", 32'(busy), 1);
    check("err_dov_c1", 32'(data_out_valid), 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 2; c < 8; c++) begin
      @(negedge clk);
      check("err_dov", 32'(data_out_valid), 0);
      check("err_done", 32'(done), 0);
      check("err_busy", 32'(busy), 0);
      check("err_pulse", 32'(err), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int k, s, d, dmin;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; start = 1'b0; ready = 1'b0;
    kernel_dim = '0; stride = '0; in_dim = '0; image_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_pass(5, 1, 32, 0, 0, 9'h011);
    run_pass(5, 1, 14, 0, 0, 9'h1a5);
    run_pass(2, 2, 28, 0, 0, 9'h040);
    run_pass(5, 1, 32, 30, 0, 9'h0f3);

    run_err(6, 1, 5);
    run_err(0, 1, 8);
    run_err(3, 0, 8);
    run_err(3, 1, 0);
    run_err(3, 1, 40);

    run_pass(5, 1, 32, 0, 1000, 9'h077);
    run_pass(5, 1, 32, 0, 0, 9'h123);

    for (int i = 0; i < 3; i++) begin
      k = int'($urandom_range(6, 2));
      s = int'($urandom_range(3, 1));
      dmin = 16;
      d = int'($urandom_range(32, dmin));
      run_pass(k, s, d, 20, 0, int'($urandom_range(511, 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
